// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between instruction fetch (I) and load/store (D) over a req/ack handshake.
// Optional watchdog: define MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT cycles and raise MemErr.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic [DW-1:0] IRdata,
    output logic          IReady,
    output logic          IStall,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWdata,
    output logic [DW-1:0] DRdata,
    output logic          DReady,
    output logic          DStall,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    input  logic [DW-1:0] MemRdata,
    input  logic          MemAck,
    output logic          Busy,
    output logic          MemErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IFETCH  = 2'b01,
        DACCESS = 2'b10
    } state_t;

    state_t        r_state;
    logic          r_last_d;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_i_ready;
    logic          r_d_ready;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_i_elig;
    logic          w_d_elig;
    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_abort;
    logic          w_done;
    logic [DW-1:0] w_rdata;

    // A requester whose Ready pulse is high right now is finishing, not asking again.
    assign w_i_elig  = IReq & ~r_i_ready;
    assign w_d_elig  = DReq & ~r_d_ready;
    assign w_grant_d = w_d_elig & (~w_i_elig | ~r_last_d);
    assign w_grant_i = w_i_elig & (~w_d_elig |  r_last_d);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_wait;
    logic       r_mem_err;

    // An ack arriving on the last allowed wait cycle still completes normally.
    assign w_abort = (r_state != IDLE) & ~MemAck & (r_wait == WAIT_LIMIT);
    assign w_rdata = w_abort ? {DW{1'b1}} : MemRdata;
    assign MemErr  = r_mem_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_wait <= '0;
            end else if (!MemAck) begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_abort) begin
                r_mem_err <= 1'b1;
            end
        end
    end
`else
    assign w_abort = 1'b0;
    assign w_rdata = MemRdata;
    // Without the watchdog there is no error source; any legal TIMEOUT (1..255) makes this 0.
    assign MemErr  = (TIMEOUT == 0);
`endif

    assign w_done = MemAck | w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last_d    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= DACCESS;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= DWe;
                        r_mem_addr  <= DAddr;
                        r_mem_wdata <= DWdata;
                    end else if (w_grant_i) begin
                        r_state    <= IFETCH;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= IAddr;
                    end
                end
                IFETCH, DACCESS: begin
                    // Completion ignores the requester's Req: an abandoned access still pulses Ready.
                    if (w_done) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_last_d  <= (r_state == DACCESS);
                        if (r_state == DACCESS) begin
                            r_d_rdata <= w_rdata;
                            r_d_ready <= 1'b1;
                        end else begin
                            r_i_rdata <= w_rdata;
                            r_i_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign MemReq   = r_mem_req;
    assign MemWe    = r_mem_we;
    assign MemAddr  = r_mem_addr;
    assign MemWdata = r_mem_wdata;
    assign IReady   = r_i_ready;
    assign DReady   = r_d_ready;
    assign IRdata   = r_i_rdata;
    assign DRdata   = r_d_rdata;
    assign IStall   = IReq & ~r_i_ready;
    assign DStall   = DReq & ~r_d_ready;
    assign Busy     = (r_state != IDLE);

endmodule
